inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage of the open_risc_v core.
- Owns the program counter and drives the instruction address to the combinational instruction ROM.
- Captures the returned word and its address into the IF/ID pipeline register for decode.
- Handles pipeline hold from downstream and jump redirection/flush from execute.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded during reset.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush.
ADDR_W, 32, address/PC width.
INST_W, 32, instruction width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
inst_addr_o  output  ADDR_W  fetch address to ROM; combinational copy of pc_q.
inst_i  input  INST_W  ROM data for inst_addr_o, valid same cycle.
hold_i  input  1  downstream stall; freeze PC and IF/ID.
jump_en_i  input  1  redirect request from execute.
jump_addr_i  input  ADDR_W  redirect target.
if_inst_o  output  INST_W  IF/ID instruction.
if_inst_addr_o  output  ADDR_W  IF/ID instruction address.
if_valid_o  output  1  IF/ID holds a real (non-bubble) instruction.
misalign_o  output  1  one-cycle pulse: last jump target had bits[1:0]!=0.
fetch_cnt_o  output  32  count of instructions captured into IF/ID.

Behaviour:
Reset (rst=1 at edge), taking priority over everything:
- pc_q=RESET_ADDR.
- if_inst_o=NOP_INST, if_inst_addr_o=0, if_valid_o=0.
- misalign_o=0, fetch_cnt_o=0.

Per-edge priority with rst=0: jump > hold > normal.

Normal (jump_en_i=0, hold_i=0):
- IF/ID <= {inst_i, pc_q, valid=1}.
- pc_q <= pc_q+4, modulo 2^32: 32'hFFFF_FFFC wraps to 0, no flag.
- fetch_cnt_o += 1, wraps at 2^32.

Hold (jump_en_i=0, hold_i=1):
- pc_q, IF/ID and fetch_cnt_o unchanged.
- inst_addr_o stays stable, so ROM output is re-presented.

Jump (jump_en_i=1, regardless of hold_i):
- pc_q <= {jump_addr_i[31:2],2'b00}.
- IF/ID <= {NOP_INST, 0, valid=0}: the word fetched this cycle is on the wrong path and is discarded.
- fetch_cnt_o unchanged.
- misalign_o <= (jump_addr_i[1:0]!=0).

misalign_o:
- Cleared on every non-jump edge, so it is a one-cycle pulse.
- A jump asserted on consecutive cycles re-evaluates the flag each cycle.

Latency:
- PC to IF/ID: 1 cycle.
- Jump to first target instruction valid in IF/ID: 2 edges (redirect edge, then capture edge).

Reset asserted mid-hold or mid-jump: reset wins and all state returns to reset values.
inst_addr_o is never registered separately from pc_q; it has no extra cycle of delay.

Decomposition:
Shared package (core_defines), used by decode/execute:
- RESET_ADDR, NOP_INST, ADDR_W, INST_W, PC_INC=4.
Sub-modules:
- pc_reg: PC register with reset, hold, jump and increment.
- inst_fetch: instantiates pc_reg and implements the IF/ID register, misalign flag and counter itself.

Test Plan:
1. Reset release, ROM[0]=32'h0010_0093, ROM[4]=32'h0020_0113, no hold/jump → inst_addr_o 0,4,8; after edge 1 if_inst_o=32'h0010_0093, if_inst_addr_o=0, valid=1; after edge 2 if_inst_o=32'h0020_0113, fetch_cnt_o=2.
2. hold_i=1 for 3 cycles at pc_q=8 → inst_addr_o stays 8; IF/ID stays {ROM[4],4,1}; fetch_cnt_o frozen; release → capture ROM[8].
3. jump_en_i=1, jump_addr_i=32'h40 together with hold_i=1 at pc_q=12 → next cycle pc_q=32'h40, if_inst_o=32'h13, valid=0, misalign_o=0; following edge if_inst_addr_o=32'h40, valid=1.
4. jump_addr_i=32'h0000_0042 → pc_q=32'h40; misalign_o=1 for exactly one cycle, then 0.
5. Force pc_q=32'hFFFF_FFFC via jump and run free → if_inst_addr_o=32'hFFFF_FFFC then next pc_q=0; no flag.
6. Assert rst during an active hold with fetch_cnt_o=5 → next cycle pc_q=RESET_ADDR, fetch_cnt_o=0, if_valid_o=0, if_inst_o=32'h13.

Source files
------------

// File: rtl/core_defines_pkg.sv
// Shared core constants for the fetch, decode and execute stages.
//   RESET_ADDR : PC value loaded by reset
//   NOP_INST   : bubble instruction (addi x0,x0,0)
//   ADDR_W     : address/PC width
//   INST_W     : instruction width
//   PC_INC     : sequential fetch stride in bytes
package core_defines;
  localparam int          ADDR_W     = 32;
  localparam int          INST_W     = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          PC_INC     = 4;
endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, loads RST_VAL
//   hold      : freeze the PC
//   jump_en   : redirect; overrides hold
//   jump_addr : redirect target; low two bits are dropped so the PC stays word aligned
//   pc        : current PC
module pc_reg
  import core_defines::*;
#(
  parameter int             AW      = 32,
  parameter logic [AW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RST_VAL;
    else if (jump_en)
      pc <= {jump_addr[AW-1:2], 2'b00};
    else if (!hold)
      pc <= pc + AW'(PC_INC);  // wraps modulo 2^AW
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// captures the returned word into the IF/ID register.
//   clk, rst        : clock and synchronous active-high reset
//   inst_addr_o     : fetch address (the PC itself, no extra register)
//   inst_i          : ROM word for inst_addr_o, same cycle
//   hold_i          : downstream stall, freezes PC, IF/ID and counter
//   jump_en_i       : redirect from execute (wins over hold)
//   jump_addr_i     : redirect target
//   if_inst_o       : IF/ID instruction
//   if_inst_addr_o  : IF/ID instruction address
//   if_valid_o      : IF/ID holds a real instruction
//   misalign_o      : one-cycle pulse when the last jump target was not word aligned
//   fetch_cnt_o     : number of instructions captured into IF/ID
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = core_defines::RESET_ADDR,
  parameter logic [31:0] NOP_INST   = core_defines::NOP_INST,
  parameter int          ADDR_W     = core_defines::ADDR_W,
  parameter int          INST_W     = core_defines::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic              hold_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [INST_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_inst_addr_o,
  output logic              if_valid_o,
  output logic              misalign_o,
  output logic [31:0]       fetch_cnt_o
);

  logic [ADDR_W-1:0] pc_q;

  pc_reg #(
    .AW      (ADDR_W),
    .RST_VAL (ADDR_W'(RESET_ADDR))
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold_i),
    .jump_en   (jump_en_i),
    .jump_addr (jump_addr_i),
    .pc        (pc_q)
  );

  assign inst_addr_o = pc_q;

  // IF/ID register. A jump squashes the word fetched this cycle since it
  // came from the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_inst_o      <= INST_W'(NOP_INST);
      if_inst_addr_o <= '0;
      if_valid_o     <= 1'b0;
    end else if (jump_en_i) begin
      if_inst_o      <= INST_W'(NOP_INST);
      if_inst_addr_o <= '0;
      if_valid_o     <= 1'b0;
    end else if (!hold_i) begin
      if_inst_o      <= inst_i;
      if_inst_addr_o <= pc_q;
      if_valid_o     <= 1'b1;
    end
  end

  // Misalign flag is re-evaluated on every jump edge and cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst)
      misalign_o <= 1'b0;
    else if (jump_en_i)
      misalign_o <= (jump_addr_i[1:0] != 2'b00);
    else
      misalign_o <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetch_cnt_o <= '0;
    else if (!jump_en_i && !hold_i)
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        hold_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_inst_addr_o;
  logic        if_valid_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM model: two fixed words at 0 and 4, an address-derived pattern elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0: rom = 32'h0010_0093;
      32'h4: rom = 32'h0020_0113;
      default: rom = a ^ 32'hDEAD_0013;
    endcase
  endfunction

  assign inst_i = rom(inst_addr_o);

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr_o    (inst_addr_o),
    .inst_i         (inst_i),
    .hold_i         (hold_i),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .if_inst_o      (if_inst_o),
    .if_inst_addr_o (if_inst_addr_o),
    .if_valid_o     (if_valid_o),
    .misalign_o     (misalign_o),
    .fetch_cnt_o    (fetch_cnt_o)
  );

  // Advance one edge and settle; inputs are changed only after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
    tick();
    n_cmp++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp %h", inst_addr_o, 32'h0); end
    n_cmp++; if (if_inst_o !== 32'h13) begin n_err++; $display("FAIL rst_inst got %h exp %h", if_inst_o, 32'h13); end
    n_cmp++; if (if_inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_iaddr got %h exp 0", if_inst_addr_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", if_valid_o); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_mis got %b exp 0", misalign_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", fetch_cnt_o); end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    tick();
    n_cmp++; if (if_inst_o !== 32'h0010_0093) begin n_err++; $display("FAIL seq1_inst got %h exp 00100093", if_inst_o); end
    n_cmp++; if (if_inst_addr_o !== 32'h0) begin n_err++; $display("FAIL seq1_iaddr got %h exp 0", if_inst_addr_o); end
    n_cmp++; if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL seq1_valid got %b exp 1", if_valid_o); end
    n_cmp++; if (inst_addr_o !== 32'h4) begin n_err++; $display("FAIL seq1_pc got %h exp 4", inst_addr_o); end
    tick();
    n_cmp++; if (if_inst_o !== 32'h0020_0113) begin n_err++; $display("FAIL seq2_inst got %h exp 00200113", if_inst_o); end
    n_cmp++; if (if_inst_addr_o !== 32'h4) begin n_err++; $display("FAIL seq2_iaddr got %h exp 4", if_inst_addr_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd2) begin n_err++; $display("FAIL seq2_cnt got %0d exp 2", fetch_cnt_o); end
    n_cmp++; if (inst_addr_o !== 32'h8) begin n_err++; $display("FAIL seq2_pc got %h exp 8", inst_addr_o); end
  endtask

  task automatic test_hold();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (inst_addr_o !== 32'h8) begin n_err++; $display("FAIL hold_pc[%0d] got %h exp 8", i, inst_addr_o); end
      n_cmp++; if (if_inst_o !== 32'h0020_0113 || if_inst_addr_o !== 32'h4 || if_valid_o !== 1'b1)
        begin n_err++; $display("FAIL hold_ifid[%0d] got %h/%h/%b exp 00200113/4/1", i, if_inst_o, if_inst_addr_o, if_valid_o); end
      n_cmp++; if (fetch_cnt_o !== 32'd2) begin n_err++; $display("FAIL hold_cnt[%0d] got %0d exp 2", i, fetch_cnt_o); end
    end
    hold_i = 1'b0;
    tick();
    n_cmp++; if (if_inst_o !== 32'hDEAD_001B) begin n_err++; $display("FAIL rel_inst got %h exp dead001b", if_inst_o); end
    n_cmp++; if (if_inst_addr_o !== 32'h8) begin n_err++; $display("FAIL rel_iaddr got %h exp 8", if_inst_addr_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd3) begin n_err++; $display("FAIL rel_cnt got %0d exp 3", fetch_cnt_o); end
    n_cmp++; if (inst_addr_o !== 32'hC) begin n_err++; $display("FAIL rel_pc got %h exp c", inst_addr_o); end
  endtask

  task automatic test_jump_over_hold();
    jump_en_i = 1'b1; jump_addr_i = 32'h40; hold_i = 1'b1;
    tick();
    n_cmp++; if (inst_addr_o !== 32'h40) begin n_err++; $display("FAIL jmp_pc got %h exp 40", inst_addr_o); end
    n_cmp++; if (if_inst_o !== 32'h13 || if_valid_o !== 1'b0 || if_inst_addr_o !== 32'h0)
      begin n_err++; $display("FAIL jmp_flush got %h/%h/%b exp 13/0/0", if_inst_o, if_inst_addr_o, if_valid_o); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL jmp_mis got %b exp 0", misalign_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd3) begin n_err++; $display("FAIL jmp_cnt got %0d exp 3", fetch_cnt_o); end
    jump_en_i = 1'b0; hold_i = 1'b0;
    tick();
    n_cmp++; if (if_inst_addr_o !== 32'h40 || if_valid_o !== 1'b1)
      begin n_err++; $display("FAIL jmp_tgt got %h/%b exp 40/1", if_inst_addr_o, if_valid_o); end
    n_cmp++; if (if_inst_o !== 32'hDEAD_0053) begin n_err++; $display("FAIL jmp_tgt_inst got %h exp dead0053", if_inst_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd4) begin n_err++; $display("FAIL jmp_tgt_cnt got %0d exp 4", fetch_cnt_o); end
  endtask

  task automatic test_misalign();
    jump_en_i = 1'b1; jump_addr_i = 32'h42;
    tick();
    n_cmp++; if (inst_addr_o !== 32'h40) begin n_err++; $display("FAIL mis_pc got %h exp 40", inst_addr_o); end
    n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %b exp 1", misalign_o); end
    jump_en_i = 1'b0;
    tick();
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b exp 0", misalign_o); end
    n_cmp++; if (fetch_cnt_o !== 32'd5) begin n_err++; $display("FAIL mis_cnt got %0d exp 5", fetch_cnt_o); end
  endtask

  task automatic test_back_to_back();
    // consecutive jumps: flag follows each target
    jump_en_i = 1'b1; jump_addr_i = 32'h81;
    tick();
    n_cmp++; if (misalign_o !== 1'b1 || inst_addr_o !== 32'h80)
      begin n_err++; $display("FAIL b2b0 got %b/%h exp 1/80", misalign_o, inst_addr_o); end
    jump_addr_i = 32'h80;
    tick();
    n_cmp++; if (misalign_o !== 1'b0 || inst_addr_o !== 32'h80)
      begin n_err++; $display("FAIL b2b1 got %b/%h exp 0/80", misalign_o, inst_addr_o); end
    jump_addr_i = 32'h83;
    tick();
    n_cmp++; if (misalign_o !== 1'b1 || inst_addr_o !== 32'h80)
      begin n_err++; $display("FAIL b2b2 got %b/%h exp 1/80", misalign_o, inst_addr_o); end
    jump_en_i = 1'b0;
    tick();
    n_cmp++; if (misalign_o !== 1'b0 || if_inst_addr_o !== 32'h80 || fetch_cnt_o !== 32'd5 + 32'd1)
      begin n_err++; $display("FAIL b2b3 got %b/%h/%0d exp 0/80/6", misalign_o, if_inst_addr_o, fetch_cnt_o); end
  endtask

  task automatic test_wrap();
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (inst_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h exp fffffffc", inst_addr_o); end
    jump_en_i = 1'b0;
    tick();
    n_cmp++; if (if_inst_addr_o !== 32'hFFFF_FFFC || if_inst_o !== 32'h2152_FFEF)
      begin n_err++; $display("FAIL wrap_ifid got %h/%h exp fffffffc/2152ffef", if_inst_addr_o, if_inst_o); end
    n_cmp++; if (inst_addr_o !== 32'h0 || misalign_o !== 1'b0)
      begin n_err++; $display("FAIL wrap_next got %h/%b exp 0/0", inst_addr_o, misalign_o); end
    tick();
    n_cmp++; if (if_inst_o !== 32'h0010_0093 || if_inst_addr_o !== 32'h0 || fetch_cnt_o !== 32'd8)
      begin n_err++; $display("FAIL wrap_after got %h/%h/%0d exp 00100093/0/8", if_inst_o, if_inst_addr_o, fetch_cnt_o); end
  endtask

  task automatic test_reset_mid_hold();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (fetch_cnt_o !== 32'd5 || inst_addr_o !== 32'h14)
      begin n_err++; $display("FAIL pre_rst got %0d/%h exp 5/14", fetch_cnt_o, inst_addr_o); end
    hold_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (inst_addr_o !== 32'h0 || fetch_cnt_o !== 32'd0)
      begin n_err++; $display("FAIL rst_hold got %h/%0d exp 0/0", inst_addr_o, fetch_cnt_o); end
    n_cmp++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h13 || if_inst_addr_o !== 32'h0)
      begin n_err++; $display("FAIL rst_hold_ifid got %b/%h/%h exp 0/13/0", if_valid_o, if_inst_o, if_inst_addr_o); end
    // reset during a misaligned jump: reset wins
    rst = 1'b0; hold_i = 1'b0;
    tick();
    tick();
    rst = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h42;
    tick();
    n_cmp++; if (inst_addr_o !== 32'h0 || misalign_o !== 1'b0 || fetch_cnt_o !== 32'd0)
      begin n_err++; $display("FAIL rst_jmp got %h/%b/%0d exp 0/0/0", inst_addr_o, misalign_o, fetch_cnt_o); end
    rst = 1'b0; jump_en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_jump_over_hold();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
